// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 frames, LSB first, idle-high line.
// The line is brought into the clk domain through two flops, the start bit is
// confirmed at its middle, and every following bit is sampled one bit period
// later. A good frame updates data with a one-cycle valid strobe; a stop bit
// sampled low raises a one-cycle frame_err and leaves data untouched.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bitValue,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  // Offset from a bit edge to its sample point (integer divide, so 0 when CLKS_PER_BIT is 1).
  localparam int          HALF     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] HALF_CNT = 16'(HALF);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        sync1;
  logic        rx_s;

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample together, giving a true two-stage chain.
      sync1 <= bitValue;
      rx_s  <= sync1;
    end
  end

  // Frame sequencer: start confirmation, mid-bit sampling, stop-bit check and strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      // NOTE: the shift register is reset along with the rest; it is small and keeps sim free of X.
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            // This cycle is start sample 0; with no offset it is already mid-bit.
            if (HALF == 0) begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end else begin
              state <= START;
              cnt   <= 16'd1;
            end
          end
        end
        START: begin
          if (cnt == HALF_CNT) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_IDLE: begin
          // A held-low (break) line must not be mistaken for a stream of start bits.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Busy whenever a frame is in progress or the line is still held low after an error.
  assign busy = (state != IDLE);

endmodule
